// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, branch flushes and data-memory freeze,
// with saturating event counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err,
  output logic [1:0]       state
);

  localparam int WAIT_W = ((TIMEOUT + 1) > 256) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic                lu;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] x);
    return (x >= WAIT_W'(TIMEOUT)) ? x : x + WAIT_W'(1);
  endfunction

  assign lu = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_d     = state_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    wait_d      = wait_q;
    err_d       = err_q;

    if (state_q == FLUSH) begin
      // ID/EX already holds the flushed bubble, so branch and load-use are moot here
      if (dmem_busy) begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end else begin
        state_d = RUN;
        wait_d  = '0;
      end
    end else if (state_q == MEM_WAIT && dmem_busy) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      wait_d = sat_inc_wait(wait_q);
    end else begin
      // RUN, or MEM_WAIT on the cycle busy drops: frozen registers are re-evaluated as-is
      if (dmem_busy) begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_d    = sat_inc_cnt(flush_q);
        state_d    = FLUSH;
        wait_d     = '0;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        stall_d     = sat_inc_cnt(stall_q);
        state_d     = RUN;
        wait_d      = '0;
      end else begin
        state_d = RUN;
        wait_d  = '0;
      end
    end

    if (dmem_busy && wait_d == WAIT_W'(TIMEOUT)) err_d = 1'b1;

    if (!rst_n) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign mem_err   = err_q;
  assign state     = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC core. It reads the fields the ID/EX register presents to EX (destination register, MEM and WB control bits) and compares them against the source registers of the instruction now in ID. It also consumes the branch-taken result from EX and a busy flag from data memory. From these it generates the write-enable, bubble and flush controls that steer the PC, IF/ID, ID/EX and EX/MEM registers, and it keeps hazard counters plus a sticky memory-timeout flag.

## Interface
- CNT_W, 32, width of the stall and flush event counters
- TIMEOUT, 255, number of consecutive dmem_busy cycles that sets mem_err (must be ≥ 1)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- ex_memread  in  1  memread bit (MEM[2]) held in ID/EX
- ex_rd  in  5  destination register held in ID/EX
- ex_branch_taken  in  1  EX stage resolved a taken branch this cycle
- dmem_busy  in  1  data memory cannot complete this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- exmem_write  out  1  EX/MEM load enable
- idex_bubble  out  1  load zeros into the ID/EX EX/MEM/WB control fields
- ifid_flush  out  1  load a NOP into IF/ID
- idex_flush  out  1  zero all ID/EX control fields
- stall_cnt  out  CNT_W  count of load-use stall cycles
- flush_cnt  out  CNT_W  count of branch flushes
- mem_err  out  1  sticky: a dmem_busy timeout occurred
- state  out  2  current FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)

## Operation
- Load-use condition: `lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`. A load into x0 never stalls.
- Default outputs: all four write enables are 1; bubble and both flushes are 0.
- Control outputs are combinational from the state register and the current inputs. Counters, mem_err and state are registered.
- RUN, first matching rule applies:
  - dmem_busy=1: all write enables 0; next state MEM_WAIT; wait_cnt←1.
  - ex_branch_taken=1: ifid_flush=1 and idex_flush=1; pc_write=1 (takes the branch target); flush_cnt++; next state FLUSH.
  - lu=1: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt++; stay in RUN. The single bubble resolves the hazard through forwarding.
  - Otherwise: stay in RUN.
- FLUSH (exactly one cycle, while ID/EX holds the flushed bubble):
  - lu and ex_branch_taken are ignored.
  - dmem_busy=1: freeze as in RUN; next state MEM_WAIT.
  - Otherwise: defaults; next state RUN.
- MEM_WAIT:
  - dmem_busy=1: all write enables 0. wait_cnt increments, saturating at TIMEOUT. If wait_cnt == TIMEOUT, mem_err←1.
  - dmem_busy=0: evaluate and drive exactly as in RUN during this same cycle, including branch and load-use handling. Next state follows the RUN rules.
- Counters saturate at all-ones and never wrap. mem_err clears only on reset.
- The internal wait counter is 8 bits minimum, or wide enough to hold TIMEOUT.

## Timing
- Controls have zero latency: they respond in the same cycle as the inputs. State and counters update on the next posedge.
- A load-use stall holds PC and IF/ID for exactly 1 cycle per lu event. If lu is still true after the bubble, a further cycle is stalled.
- A branch flush costs 2 cycles: the flush cycle plus the FLUSH state cycle.
- Simultaneous dmem_busy, branch and lu: busy wins. The branch and lu are re-evaluated in the cycle busy drops, because all pipeline registers were frozen and their contents are unchanged.
- Reset: while rst_n=0 at a posedge, the following take effect on that edge:
  - state←RUN, stall_cnt←0, flush_cnt←0, mem_err←0, wait_cnt←0.
  - While rst_n=0, outputs are forced to all write enables 0 and bubble/flushes 0.
  - Reset asserted mid-MEM_WAIT or mid-FLUSH abandons the state with no residue.

## Test plan
- Load x5 into ID/EX (ex_memread=1, ex_rd=5) with id_rs2=5 → pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle; stall_cnt=1; next cycle all enables 1.
- ex_memread=1, ex_rd=0, id_rs1=0 → no stall; stall_cnt stays 0.
- ex_branch_taken=1 with lu=1 in the same cycle → ifid_flush=idex_flush=1, no stall; state=FLUSH; flush_cnt=1; next cycle lu is ignored and the FSM returns to RUN.
- dmem_busy=1 for 3 cycles with ex_branch_taken=1 held throughout → enables 0 for 3 cycles; in cycle 4 (busy=0) the flush fires; flush_cnt=1.
- TIMEOUT=4 with dmem_busy held for 6 cycles → mem_err rises after the 4th busy edge and stays 1 after busy drops; it is cleared only by rst_n=0 for one edge.
- Assert rst_n=0 during MEM_WAIT → next edge gives state=0 and counters=0; outputs are forced to 0 while reset is held.
